rs232c_tx_arbiter: RTL

- Round-robin scheduler that shares one RS-232C byte transmitter (te / t_busy / send_data / max_count interface) between NUM_REQ requesters.
- Each requester submits one multi-byte word (e.g. a tremor sample). The block serialises it into BYTES_PER_WORD bytes and sequences each byte through the transmitter.
- Owns the transmitter's bit-period configuration (max_count). Updates are applied only between words.

---
 rtl/rs232c_tx_arbiter_if.sv | 35 +++
 rtl/rs232c_tx_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rs232c_tx_arbiter_if.sv
// Requester, configuration and transmitter-side signals of the RS-232C transmit arbiter.
// master is the surrounding system (requesters, config, transmitter); slave is the arbiter.
interface rs232c_tx_arbiter_if #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned BIT_WIDTH      = 8
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                          req_valid;
    logic [NUM_REQ*BYTES_PER_WORD*BIT_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                          req_ready;
    logic [31:0]                                 cfg_max_count;
    logic                                        cfg_update;
    logic [BIT_WIDTH-1:0]                        tx_send_data;
    logic                                        tx_te;
    logic [31:0]                                 tx_max_count;
    logic                                        tx_busy;
    logic [IdW-1:0]                              grant_id;
    logic                                        busy;
    logic                                        word_done;
    logic                                        err_no_busy;

    modport master (
        output req_valid, req_data, cfg_max_count, cfg_update, tx_busy,
        input  req_ready, tx_send_data, tx_te, tx_max_count, grant_id, busy, word_done,
               err_no_busy
    );

    modport slave (
        input  req_valid, req_data, cfg_max_count, cfg_update, tx_busy,
        output req_ready, tx_send_data, tx_te, tx_max_count, grant_id, busy, word_done,
               err_no_busy
    );
endinterface

// File: rtl/rs232c_tx_arbiter.sv
// Round-robin scheduler sharing one RS-232C byte transmitter between NUM_REQ requesters;
// each granted word is split into bytes and sequenced through te/t_busy.
module rs232c_tx_arbiter #(
    parameter int unsigned NUM_REQ           = 2,
    parameter int unsigned BYTES_PER_WORD    = 4,
    parameter int unsigned BIT_WIDTH         = 8,
    parameter bit          MSB_FIRST         = 1'b0,
    parameter int unsigned DEFAULT_MAX_COUNT = 10416
) (
    input logic               clk,
    input logic               rst,
    rs232c_tx_arbiter_if.slave bus
);
    localparam int unsigned IdW      = $clog2(NUM_REQ);
    localparam int unsigned WordW    = BYTES_PER_WORD * BIT_WIDTH;
    localparam int unsigned ByteIdxW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StLoad,
        StWaitBusy,
        StWaitDone,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [IdW-1:0]        grant_q, grant_d;
    logic [IdW-1:0]        rr_q, rr_d;
    logic [ByteIdxW-1:0]   byte_idx_q, byte_idx_d;
    logic [WordW-1:0]      buf_q, buf_d;
    logic [1:0]            wait_cnt_q, wait_cnt_d;
    logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
    logic                  tx_te_q, tx_te_d;
    logic [BIT_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic [31:0]           max_q, max_d;
    logic                  busy_q, busy_d;
    logic                  word_done_q, word_done_d;
    logic                  err_q, err_d;
    logic                  cfg_pend_q, cfg_pend_d;
    logic [31:0]           cfg_val_q, cfg_val_d;

    logic                  found;
    logic [IdW-1:0]        winner;
    logic [WordW-1:0]      grant_word;

    function automatic logic [BIT_WIDTH-1:0] pick_byte(input logic [WordW-1:0]    word,
                                                        input logic [ByteIdxW-1:0] idx);
        int unsigned pos;
        pos = MSB_FIRST ? (BYTES_PER_WORD - 1 - int'(idx)) : int'(idx);
        return word[pos*BIT_WIDTH +: BIT_WIDTH];
    endfunction

    // First valid requester at or after the round-robin pointer, wrapping upward.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = IdW'(idx);
            end
        end
    end

    assign grant_word = bus.req_data[int'(grant_q)*WordW +: WordW];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        byte_idx_d  = byte_idx_q;
        buf_d       = buf_q;
        wait_cnt_d  = wait_cnt_q;
        req_ready_d = '0;
        tx_te_d     = 1'b0;
        tx_data_d   = tx_data_q;
        max_d       = max_q;
        word_done_d = 1'b0;
        err_d       = err_q;
        cfg_pend_d  = cfg_pend_q;
        cfg_val_d   = cfg_val_q;

        if (bus.cfg_update) begin
            cfg_pend_d = 1'b1;
            cfg_val_d  = bus.cfg_max_count;
        end

        unique case (state_q)
            StIdle: begin
                // A strobe in this very cycle wins over an older pending value.
                if (bus.cfg_update) begin
                    max_d      = bus.cfg_max_count;
                    cfg_pend_d = 1'b0;
                end else if (cfg_pend_q) begin
                    max_d      = cfg_val_q;
                    cfg_pend_d = 1'b0;
                end
                if (found) begin
                    grant_d             = winner;
                    req_ready_d[winner] = 1'b1;
                    state_d             = StGrant;
                end
            end
            StGrant: begin
                buf_d      = grant_word;
                byte_idx_d = '0;
                rr_d       = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + IdW'(1);
                tx_data_d  = pick_byte(grant_word, '0);
                tx_te_d    = 1'b1;
                state_d    = StLoad;
            end
            StLoad: begin
                wait_cnt_d = '0;
                state_d    = StWaitBusy;
            end
            StWaitBusy: begin
                // Third sampled cycle without t_busy means err_no_busy shows 4 cycles after te.
                if (bus.tx_busy) begin
                    state_d = StWaitDone;
                end else if (wait_cnt_q == 2'd2) begin
                    err_d       = 1'b1;
                    word_done_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            StWaitDone: begin
                if (!bus.tx_busy) begin
                    if (byte_idx_q == LastByte) begin
                        word_done_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        byte_idx_d = byte_idx_q + ByteIdxW'(1);
                        tx_data_d  = pick_byte(buf_q, byte_idx_q + ByteIdxW'(1));
                        tx_te_d    = 1'b1;
                        state_d    = StLoad;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_q        <= '0;
            byte_idx_q  <= '0;
            buf_q       <= '0;
            wait_cnt_q  <= '0;
            req_ready_q <= '0;
            tx_te_q     <= 1'b0;
            tx_data_q   <= '0;
            max_q       <= 32'(DEFAULT_MAX_COUNT);
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
            err_q       <= 1'b0;
            cfg_pend_q  <= 1'b0;
            cfg_val_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            byte_idx_q  <= byte_idx_d;
            buf_q       <= buf_d;
            wait_cnt_q  <= wait_cnt_d;
            req_ready_q <= req_ready_d;
            tx_te_q     <= tx_te_d;
            tx_data_q   <= tx_data_d;
            max_q       <= max_d;
            busy_q      <= busy_d;
            word_done_q <= word_done_d;
            err_q       <= err_d;
            cfg_pend_q  <= cfg_pend_d;
            cfg_val_q   <= cfg_val_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.tx_te        = tx_te_q;
    assign bus.tx_send_data = tx_data_q;
    assign bus.tx_max_count = max_q;
    assign bus.grant_id     = grant_q;
    assign bus.busy         = busy_q;
    assign bus.word_done    = word_done_q;
    assign bus.err_no_busy  = err_q;
endmodule
